// File: rtl/bus_addr_decoder.sv
// Routes the arbitrated master bus to the memory or peripheral slave by address window,
// returns a one-cycle ack with read data, and flags unmapped addresses and slave timeouts.
module bus_addr_decoder #(
    parameter logic [31:0] MEM_BASE = 32'h0000_0000,
    parameter logic [31:0] MEM_MASK = 32'hFFFF_0000,
    parameter logic [31:0] PER_BASE = 32'h8000_0000,
    parameter logic [31:0] PER_MASK = 32'hFFFF_F000,
    parameter int unsigned TIMEOUT  = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bus_en,
    input  logic        i_wr_rd,
    input  logic [31:0] i_wr_data,
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_size,
    output logic        o_ack,
    output logic        o_err,
    output logic [31:0] o_rd_data,
    output logic        o_mem_en,
    output logic        o_per_en,
    output logic        o_s_wr_rd,
    output logic [31:0] o_s_wr_data,
    output logic [31:0] o_s_addr,
    output logic [2:0]  o_s_size,
    input  logic        i_mem_ack,
    input  logic        i_per_ack,
    input  logic [31:0] i_mem_rd_data,
    input  logic [31:0] i_per_rd_data
);

    localparam int          CNT_W      = $clog2(TIMEOUT) + 1;
    localparam int unsigned CNT_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_LAST_I[CNT_W-1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              mem_en_q,    mem_en_d;
    logic              per_en_q,    per_en_d;
    logic              s_wr_rd_q,   s_wr_rd_d;
    logic [31:0]       s_wr_data_q, s_wr_data_d;
    logic [31:0]       s_addr_q,    s_addr_d;
    logic [2:0]        s_size_q,    s_size_d;
    logic              ack_q,       ack_d;
    logic              err_q,       err_d;
    logic [31:0]       rd_data_q,   rd_data_d;

    logic        mem_hit;
    logic        per_hit;
    logic        sel_ack;
    logic [31:0] sel_data;
    logic        timeout_hit;

    assign mem_hit     = (i_addr & MEM_MASK) == MEM_BASE;
    assign per_hit     = (i_addr & PER_MASK) == PER_BASE;
    // Only the slave we enabled may complete the transaction.
    assign sel_ack     = (mem_en_q & i_mem_ack) | (per_en_q & i_per_ack);
    assign sel_data    = mem_en_q ? i_mem_rd_data : i_per_rd_data;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // NOTE: every *_d gets a default before the case so no path leaves it unassigned
    // (no latches); blocking '=' here, non-blocking '<=' only in the clocked block.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        per_en_d    = per_en_q;
        s_wr_rd_d   = s_wr_rd_q;
        s_wr_data_d = s_wr_data_q;
        s_addr_d    = s_addr_q;
        s_size_d    = s_size_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        rd_data_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (i_bus_en) begin
                    s_wr_rd_d   = i_wr_rd;
                    s_wr_data_d = i_wr_data;
                    s_addr_d    = i_addr;
                    s_size_d    = i_size;
                    cnt_d       = '0;
                    if (mem_hit) begin
                        mem_en_d = 1'b1;
                        state_d  = WAIT;
                    end else if (per_hit) begin
                        per_en_d = 1'b1;
                        state_d  = WAIT;
                    end else begin
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (sel_ack) begin
                    mem_en_d  = 1'b0;
                    per_en_d  = 1'b0;
                    ack_d     = 1'b1;
                    rd_data_d = s_wr_rd_q ? 32'd0 : sel_data;
                    state_d   = RESP;
                end else if (timeout_hit) begin
                    mem_en_d = 1'b0;
                    per_en_d = 1'b0;
                    ack_d    = 1'b1;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            per_en_q    <= 1'b0;
            s_wr_rd_q   <= 1'b0;
            s_wr_data_q <= '0;
            s_addr_q    <= '0;
            s_size_q    <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            per_en_q    <= per_en_d;
            s_wr_rd_q   <= s_wr_rd_d;
            s_wr_data_q <= s_wr_data_d;
            s_addr_q    <= s_addr_d;
            s_size_q    <= s_size_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign o_ack       = ack_q;
    assign o_err       = err_q;
    assign o_rd_data   = rd_data_q;
    assign o_mem_en    = mem_en_q;
    assign o_per_en    = per_en_q;
    assign o_s_wr_rd   = s_wr_rd_q;
    assign o_s_wr_data = s_wr_data_q;
    assign o_s_addr    = s_addr_q;
    assign o_s_size    = s_size_q;

endmodule

// File: tb/tb_bus_addr_decoder.sv
// Directed bench for bus_addr_decoder: expected responses are queued when a request is driven
// and compared when o_ack appears.
module tb_bus_addr_decoder;

    logic        i_clk;
    logic        i_rst;
    logic        i_bus_en;
    logic        i_wr_rd;
    logic [31:0] i_wr_data;
    logic [31:0] i_addr;
    logic [2:0]  i_size;
    logic        o_ack;
    logic        o_err;
    logic [31:0] o_rd_data;
    logic        o_mem_en;
    logic        o_per_en;
    logic        o_s_wr_rd;
    logic [31:0] o_s_wr_data;
    logic [31:0] o_s_addr;
    logic [2:0]  o_s_size;
    logic        i_mem_ack;
    logic        i_per_ack;
    logic [31:0] i_mem_rd_data;
    logic [31:0] i_per_rd_data;

    bus_addr_decoder #(.TIMEOUT(8)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_bus_en      (i_bus_en),
        .i_wr_rd       (i_wr_rd),
        .i_wr_data     (i_wr_data),
        .i_addr        (i_addr),
        .i_size        (i_size),
        .o_ack         (o_ack),
        .o_err         (o_err),
        .o_rd_data     (o_rd_data),
        .o_mem_en      (o_mem_en),
        .o_per_en      (o_per_en),
        .o_s_wr_rd     (o_s_wr_rd),
        .o_s_wr_data   (o_s_wr_data),
        .o_s_addr      (o_s_addr),
        .o_s_size      (o_s_size),
        .i_mem_ack     (i_mem_ack),
        .i_per_ack     (i_per_ack),
        .i_mem_rd_data (i_mem_rd_data),
        .i_per_rd_data (i_per_rd_data)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, required finish within 100us");
        $fatal(1);
    end

    task automatic step();
        @(negedge i_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [2:0] size, input bit push_exp, input logic exp_err,
                       input logic [31:0] exp_data, input string tag);
        exp_t e;
        step();
        i_bus_en  = 1'b1;
        i_wr_rd   = wr;
        i_addr    = addr;
        i_wr_data = data;
        i_size    = size;
        if (push_exp) begin
            e.err  = exp_err;
            e.data = exp_data;
            e.tag  = tag;
            sb.push_back(e);
        end
    endtask

    // Waits up to budget cycles for o_ack, then scores against the oldest queued response.
    task automatic wait_resp(input int budget);
        exp_t e;
        int   n = 0;
        while (o_ack !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check("ack_seen", 32'(o_ack), 32'd1);
        if (o_ack === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(o_ack), 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_err"},  32'(o_err), 32'(e.err));
                check({e.tag, "_data"}, o_rd_data,  e.data);
            end
        end
        i_bus_en = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack"},     32'(o_ack),     32'd0);
        check({tag, "_err"},     32'(o_err),     32'd0);
        check({tag, "_rd_data"}, o_rd_data,      32'd0);
        check({tag, "_mem_en"},  32'(o_mem_en),  32'd0);
        check({tag, "_per_en"},  32'(o_per_en),  32'd0);
    endtask

    initial begin
        i_rst         = 1'b0;
        i_bus_en      = 1'b0;
        i_wr_rd       = 1'b0;
        i_wr_data     = '0;
        i_addr        = '0;
        i_size        = '0;
        i_mem_ack     = 1'b0;
        i_per_ack     = 1'b0;
        i_mem_rd_data = '0;
        i_per_rd_data = '0;

        // Reset state
        repeat (3) step();
        check_idle_outputs("reset");
        check("reset_s_addr",    o_s_addr,        32'd0);
        check("reset_s_wr_data", o_s_wr_data,     32'd0);
        check("reset_s_size",    32'(o_s_size),   32'd0);
        check("reset_s_wr_rd",   32'(o_s_wr_rd),  32'd0);
        i_rst = 1'b1;

        // Memory read, slave acks two cycles after its enable rises
        req(1'b0, 32'h0000_0010, 32'h0, 3'd2, 1'b1, 1'b0, 32'hDEAD_BEEF, "mem_rd");
        step();
        check("mem_rd_mem_en_c1", 32'(o_mem_en), 32'd1);
        check("mem_rd_per_en_c1", 32'(o_per_en), 32'd0);
        check("mem_rd_s_addr",    o_s_addr,       32'h0000_0010);
        check("mem_rd_ack_c1",    32'(o_ack),     32'd0);
        step();
        check("mem_rd_mem_en_c2", 32'(o_mem_en), 32'd1);
        check("mem_rd_per_en_c2", 32'(o_per_en), 32'd0);
        step();
        i_mem_ack     = 1'b1;
        i_mem_rd_data = 32'hDEAD_BEEF;
        check("mem_rd_per_en_c3", 32'(o_per_en), 32'd1 - 32'd1);
        step();
        i_mem_ack = 1'b0;
        wait_resp(0);
        check("mem_rd_mem_en_resp", 32'(o_mem_en), 32'd0);
        step();
        check("mem_rd_ack_pulse", 32'(o_ack),  32'd0);
        check("mem_rd_data_clr",  o_rd_data,   32'd0);

        // Peripheral write: returned data must be zero even if the slave drives its bus
        req(1'b1, 32'h8000_0004, 32'h1234_5678, 3'b010, 1'b1, 1'b0, 32'h0, "per_wr");
        step();
        check("per_wr_per_en",    32'(o_per_en),  32'd1);
        check("per_wr_mem_en",    32'(o_mem_en),  32'd0);
        check("per_wr_s_wr_data", o_s_wr_data,    32'h1234_5678);
        check("per_wr_s_size",    32'(o_s_size),  32'd2);
        check("per_wr_s_wr_rd",   32'(o_s_wr_rd), 32'd1);
        i_per_ack     = 1'b1;
        i_per_rd_data = 32'hFFFF_FFFF;
        step();
        i_per_ack = 1'b0;
        wait_resp(0);

        // Unmapped address answers in the cycle after accept with no slave enable
        req(1'b0, 32'h4000_0000, 32'h0, 3'd0, 1'b1, 1'b1, 32'h0, "unmapped");
        step();
        check("unmapped_mem_en", 32'(o_mem_en), 32'd0);
        check("unmapped_per_en", 32'(o_per_en), 32'd0);
        wait_resp(0);

        // Timeout: enable stays high for exactly TIMEOUT cycles, then an error response
        req(1'b0, 32'h0000_0100, 32'h0, 3'd2, 1'b1, 1'b1, 32'h0, "timeout");
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("timeout_mem_en_c%0d", i), 32'(o_mem_en), 32'd1);
        end
        step();
        check("timeout_mem_en_drop", 32'(o_mem_en), 32'd0);
        wait_resp(0);
        i_mem_ack     = 1'b1;
        i_mem_rd_data = 32'h5555_AAAA;
        step();
        check("late_ack_idle", 32'(o_ack),  32'd0);
        check("late_ack_data", o_rd_data,   32'd0);
        i_mem_ack = 1'b0;
        step();
        check_idle_outputs("late_ack_after");

        // Ack on the same edge as the timeout terminal count wins
        req(1'b0, 32'h0000_0200, 32'h0, 3'd2, 1'b1, 1'b0, 32'h0BAD_F00D, "tc_ack");
        repeat (8) step();
        check("tc_ack_mem_en_c8", 32'(o_mem_en), 32'd1);
        i_mem_ack     = 1'b1;
        i_mem_rd_data = 32'h0BAD_F00D;
        step();
        i_mem_ack = 1'b0;
        wait_resp(0);

        // Peripheral ack while memory is selected is ignored
        req(1'b0, 32'h0000_0020, 32'h0, 3'd2, 1'b1, 1'b0, 32'hCAFE_F00D, "cross_ack");
        step();
        i_per_ack     = 1'b1;
        i_per_rd_data = 32'h1111_1111;
        step();
        i_per_ack = 1'b0;
        check("cross_ack_mem_en", 32'(o_mem_en), 32'd1);
        check("cross_ack_no_ack", 32'(o_ack),    32'd0);
        i_mem_ack     = 1'b1;
        i_mem_rd_data = 32'hCAFE_F00D;
        step();
        i_mem_ack = 1'b0;
        wait_resp(0);

        // Reset in WAIT abandons the transaction
        req(1'b1, 32'h0000_0030, 32'h7777_7777, 3'd1, 1'b0, 1'b0, 32'h0, "rst_wait");
        step();
        check("rst_wait_mem_en", 32'(o_mem_en), 32'd1);
        i_rst    = 1'b0;
        i_bus_en = 1'b0;
        step();
        check_idle_outputs("rst_wait");
        check("rst_wait_s_addr",    o_s_addr,       32'd0);
        check("rst_wait_s_wr_data", o_s_wr_data,    32'd0);
        check("rst_wait_s_size",    32'(o_s_size),  32'd0);
        check("rst_wait_s_wr_rd",   32'(o_s_wr_rd), 32'd0);
        i_rst = 1'b1;

        // Window edges after reset
        req(1'b0, 32'h8000_0FFC, 32'h0, 3'd2, 1'b1, 1'b0, 32'hA5A5_5A5A, "per_top");
        step();
        check("per_top_per_en", 32'(o_per_en), 32'd1);
        i_per_ack     = 1'b1;
        i_per_rd_data = 32'hA5A5_5A5A;
        step();
        i_per_ack = 1'b0;
        wait_resp(4);

        req(1'b0, 32'h8000_1000, 32'h0, 3'd2, 1'b1, 1'b1, 32'h0, "per_above");
        step();
        check("per_above_per_en", 32'(o_per_en), 32'd0);
        wait_resp(0);

        req(1'b0, 32'h0000_FFFC, 32'h0, 3'd2, 1'b1, 1'b0, 32'h0F0F_F0F0, "mem_top");
        step();
        check("mem_top_mem_en", 32'(o_mem_en), 32'd1);
        i_mem_ack     = 1'b1;
        i_mem_rd_data = 32'h0F0F_F0F0;
        step();
        i_mem_ack = 1'b0;
        wait_resp(4);

        step();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
